regfile_param: RTL and testbench

Parametrised register file, the next generation of the fixed 32x32, 2-read-port file used by the processor datapath. Width, depth and read-port count are configurable. Adds same-cycle write-to-read bypass, an optional hardwired zero register, and a one-register-per-cycle clear sweep engine with a busy indication. Writes occur on the rising edge of clock.

---
 rtl/regfile_param.sv | 110 +++++++++++
 tb/tb_regfile_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with same-cycle write bypass, optional
// hardwired zero register and a one-entry-per-cycle clear sweep.
module regfile_param_rdport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic                  wr_acc_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] stored_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    // Zero register wins over bypass, bypass wins over stored contents.
    always_comb begin
        rdata_o = stored_i;
        if (BYPASS != 0 && wr_acc_i && raddr_i == waddr_i)
            rdata_o = wdata_i;
        if (ZERO_REG != 0 && raddr_i == '0)
            rdata_o = '0;
    end
endmodule

module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           ctrl_reset,
    input  logic                           ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    input  logic                           ctrl_clear,
    output logic                           clear_busy,
    output logic                           write_dropped
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  busy_q, drop_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_acc;

    assign wr_acc        = ctrl_writeEnable && (state_q == IDLE);
    assign ptr_d         = ptr_q + 1'b1;
    assign clear_busy    = busy_q;
    assign write_dropped = drop_q;

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (wr_acc && !(ZERO_REG != 0 && ctrl_writeReg == '0))
                        mem_q[ctrl_writeReg] <= data_writeReg;
                    if (ctrl_clear) begin
                        state_q <= SWEEP;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    // Writes are rejected here; flag it for exactly one cycle.
                    drop_q       <= ctrl_writeEnable;
                    mem_q[ptr_q] <= '0;
                    ptr_q        <= ptr_d;
                    if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] raddr;
        assign raddr = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];
        regfile_param_rdport #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .ZERO_REG  (ZERO_REG),
            .BYPASS    (BYPASS)
        ) u_rd (
            .raddr_i (raddr),
            .waddr_i (ctrl_writeReg),
            .wr_acc_i(wr_acc),
            .wdata_i (data_writeReg),
            .stored_i(mem_q[raddr]),
            .rdata_o (data_readReg[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: three configurations driven with shared stimulus and
// compared against a rule-level model, plus hand-computed vector table.
module tb_regfile_param;
    logic        clock = 1'b0;
    logic        rst, we, clr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra [3];
    logic [63:0] rd_a, rd_b;
    logic [47:0] rd_c;
    logic        busy_o [3];
    logic        drop_o [3];

    always #5 clock = ~clock;

    // A: default, B: no bypass / ordinary r0, C: 16-bit, 8 entries, 3 ports
    regfile_param u_a (
        .clock(clock), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wa),
        .data_writeReg(wd), .ctrl_readReg({ra[1], ra[0]}), .data_readReg(rd_a),
        .ctrl_clear(clr), .clear_busy(busy_o[0]), .write_dropped(drop_o[0]));
    regfile_param #(.ZERO_REG(0), .BYPASS(0)) u_b (
        .clock(clock), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wa),
        .data_writeReg(wd), .ctrl_readReg({ra[1], ra[0]}), .data_readReg(rd_b),
        .ctrl_clear(clr), .clear_busy(busy_o[1]), .write_dropped(drop_o[1]));
    regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(3)) u_c (
        .clock(clock), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wa[2:0]),
        .data_writeReg(wd[15:0]), .ctrl_readReg({ra[2][2:0], ra[1][2:0], ra[0][2:0]}),
        .data_readReg(rd_c), .ctrl_clear(clr), .clear_busy(busy_o[2]),
        .write_dropped(drop_o[2]));

    int          n_cmp = 0;
    int          n_err = 0;
    int          ZR  [3] = '{1, 0, 1};
    int          BYP [3] = '{1, 0, 1};
    int          DEP [3] = '{32, 32, 8};
    int          NR  [3] = '{2, 2, 3};
    logic [31:0] DM  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};

    logic [31:0] mdl   [3][32];
    int          mptr  [3];
    bit          mbusy [3];
    bit          mdrop [3];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_rd(input int i, input int k);
        case (i)
            0:       return rd_a[k*32 +: 32];
            1:       return rd_b[k*32 +: 32];
            default: return {16'h0, rd_c[k*16 +: 16]};
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a);
        int ad = int'(a) % DEP[i];
        int w  = int'(wa) % DEP[i];
        if (ZR[i] != 0 && ad == 0) return 32'h0;
        if (BYP[i] != 0 && we && !mbusy[i] && ad == w) return wd & DM[i];
        return mdl[i][ad];
    endfunction

    task automatic chk_model(input string tag);
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < NR[i]; k++)
                cmp($sformatf("%s dut%0d rd%0d", tag, i, k), get_rd(i, k), exp_rd(i, ra[k]));
            cmp($sformatf("%s dut%0d busy", tag, i), {31'h0, busy_o[i]}, {31'h0, mbusy[i]});
            cmp($sformatf("%s dut%0d drop", tag, i), {31'h0, drop_o[i]}, {31'h0, mdrop[i]});
        end
    endtask

    // Advance the model by the rules for one rising edge, using current inputs.
    task automatic clk_edge();
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            int w = int'(wa) % DEP[i];
            if (!rst) begin
                for (int j = 0; j < 32; j++) mdl[i][j] = 32'h0;
                mbusy[i] = 0; mptr[i] = 0; mdrop[i] = 0;
            end else if (!mbusy[i]) begin
                if (we && !(ZR[i] != 0 && w == 0)) mdl[i][w] = wd & DM[i];
                mdrop[i] = 0;
                if (clr) begin mbusy[i] = 1; mptr[i] = 0; end
            end else begin
                mdl[i][mptr[i]] = 32'h0;
                mdrop[i] = we;
                mptr[i]++;
                if (mptr[i] == DEP[i]) begin mbusy[i] = 0; mptr[i] = 0; end
            end
        end
        #1;
    endtask

    task automatic step(input string tag);
        #2;
        chk_model(tag);
        clk_edge();
    endtask

    function automatic logic [31:0] fillv(input int j);
        return 32'h5A00_0000 | (j * 32'h0001_0101);
    endfunction

    typedef struct {
        logic        rst, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0, r1;
        logic [31:0] ea0, ea1, eb0;
    } vec_t;

    vec_t tv [9];
    int   cnta, cntc, ndrop;

    initial begin
        tv[0] = '{1'b0, 1'b0, 5'd0, 32'h0,          5'd5, 5'd0, 32'h0,          32'h0,        32'h0};
        tv[1] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF,   5'd5, 5'd0, 32'hDEADBEEF,   32'h0,        32'h0};
        tv[2] = '{1'b1, 1'b0, 5'd0, 32'h0,          5'd5, 5'd0, 32'hDEADBEEF,   32'h0,        32'hDEADBEEF};
        tv[3] = '{1'b1, 1'b1, 5'd7, 32'h12345678,   5'd7, 5'd7, 32'h12345678,   32'h12345678, 32'h0};
        tv[4] = '{1'b1, 1'b0, 5'd0, 32'h0,          5'd7, 5'd7, 32'h12345678,   32'h12345678, 32'h12345678};
        tv[5] = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF,   5'd0, 5'd0, 32'h0,          32'h0,        32'h0};
        tv[6] = '{1'b1, 1'b0, 5'd0, 32'h0,          5'd0, 5'd5, 32'h0,          32'hDEADBEEF, 32'hFFFFFFFF};
        tv[7] = '{1'b1, 1'b1, 5'd7, 32'hCAFEF00D,   5'd7, 5'd5, 32'hCAFEF00D,   32'hDEADBEEF, 32'h12345678};
        tv[8] = '{1'b1, 1'b0, 5'd0, 32'h0,          5'd7, 5'd7, 32'hCAFEF00D,   32'hCAFEF00D, 32'hCAFEF00D};

        rst = 0; we = 0; clr = 0; wa = 0; wd = 0;
        for (int k = 0; k < 3; k++) ra[k] = 0;
        #1;
        clk_edge();

        // Defaults, bypass and zero-register vectors
        for (int v = 0; v < 9; v++) begin
            rst = tv[v].rst; we = tv[v].we; wa = tv[v].wa; wd = tv[v].wd;
            ra[0] = tv[v].r0; ra[1] = tv[v].r1; ra[2] = 0;
            #2;
            chk_model($sformatf("vec%0d", v));
            cmp($sformatf("vec%0d A.p0", v), get_rd(0, 0), tv[v].ea0);
            cmp($sformatf("vec%0d A.p1", v), get_rd(0, 1), tv[v].ea1);
            cmp($sformatf("vec%0d B.p0", v), get_rd(1, 0), tv[v].eb0);
            clk_edge();
        end

        // Fill and sweep
        we = 1;
        for (int j = 1; j < 32; j++) begin
            wa = 5'(j); wd = fillv(j); step("fill");
        end
        we = 0; clr = 1; ra[0] = 2; ra[1] = 1; ra[2] = 3;
        step("clr");
        clr = 0; cnta = 0; cntc = 0;
        for (int c = 0; c < 40; c++) begin
            #2;
            chk_model("sweep");
            if (busy_o[0]) cnta++;
            if (busy_o[2]) cntc++;
            if (cnta == 3 && busy_o[0]) begin
                cmp("sweep3 r2 old", get_rd(0, 0), fillv(2));
                cmp("sweep3 r1 zero", get_rd(0, 1), 32'h0);
            end
            clk_edge();
        end
        cmp("busy cycles A", cnta, 32);
        cmp("busy cycles C", cntc, 8);
        for (int j = 0; j < 32; j++) begin
            ra[0] = 5'(j); ra[1] = 5'(31 - j);
            #2;
            chk_model("post sweep");
            cmp("post sweep A zero", get_rd(0, 0), 32'h0);
            clk_edge();
        end

        // Dropped write and ignored re-clear during sweep
        we = 1;
        for (int j = 1; j < 32; j++) begin
            wa = 5'(j); wd = ~fillv(j); step("refill");
        end
        we = 0; clr = 1; step("clr2");
        clr = 0; cnta = 0; ndrop = 0; ra[0] = 31; ra[1] = 30;
        for (int c = 1; c <= 40; c++) begin
            we = (c == 5); wa = 31; wd = 32'hAAAA_0000; clr = (c == 10);
            #2;
            chk_model("wsweep");
            if (busy_o[0]) cnta++;
            if (drop_o[0]) ndrop++;
            if (c == 6) cmp("drop pulse A", {31'h0, drop_o[0]}, 32'h1);
            clk_edge();
        end
        we = 0; clr = 0;
        cmp("busy cycles A reclear", cnta, 32);
        cmp("drop pulse count A", ndrop, 1);
        #2;
        cmp("r31 after sweep", get_rd(0, 0), 32'h0);
        chk_model("after wsweep");
        clk_edge();

        // Reset in the middle of a sweep
        we = 1; wa = 9; wd = 32'h9999_9999; step("pre rst write");
        we = 0; clr = 1; step("clr3");
        clr = 0; ra[0] = 9; ra[1] = 31;
        for (int c = 1; c <= 12; c++) begin
            rst = (c != 10);
            #2;
            chk_model("rst sweep");
            if (c == 11) begin
                cmp("busy after rst", {31'h0, busy_o[0]}, 32'h0);
                cmp("r9 after rst", get_rd(0, 0), 32'h0);
            end
            clk_edge();
        end
        rst = 1;

        // Narrow configuration: three simultaneous ports
        we = 1;
        wa = 1; wd = 32'h0001_1111; step("c w1");
        wa = 2; wd = 32'h0002_2222; step("c w2");
        wa = 7; wd = 32'h0007_7777; step("c w7");
        we = 0; ra[0] = 1; ra[1] = 2; ra[2] = 7;
        #2;
        chk_model("c read");
        cmp("C p0 r1", get_rd(2, 0), 32'h1111);
        cmp("C p1 r2", get_rd(2, 1), 32'h2222);
        cmp("C p2 r7", get_rd(2, 2), 32'h7777);
        clk_edge();

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(99) != 0);
            we  = rst ? 1'($urandom_range(1)) : 1'b0;
            wa  = 5'($urandom);
            wd  = $urandom;
            clr = ($urandom_range(29) == 0);
            for (int k = 0; k < 3; k++) ra[k] = 5'($urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
